// File: rtl/rf_bank_arbiter.sv
// rf_bank_arbiter
//   Per-bank arbiter between the operand collectors (OCs) and the CDB
//   writeback port of a banked register file. Each cycle, every bank gets at
//   most one command: the writeback, or one OC read picked round-robin. A
//   per-bank starvation counter forces a pending read through after
//   STARVE_LIMIT consecutive write-won cycles. Commands are registered and go
//   straight to the bank pins, tagged with the requesting OC id.
//
// Ports
//   clk           clock, all state on posedge
//   rst           asynchronous reset, active-low
//   oc_req_valid  [NUM_OC]          OC i has a read request
//   oc_req_bank   [NUM_OC*BANK_W]   target bank of OC i
//   oc_req_row    [NUM_OC*ROW_W]    target row of OC i
//   oc_req_ready  [NUM_OC]          combinational grant (valid & ready = handshake)
//   wb_valid      writeback request
//   wb_bank       writeback bank
//   wb_row        writeback row
//   wb_ready      combinational writeback accept (independent of wb_valid)
//   bank_en       [NUM_BANK]          registered: bank has a command
//   bank_wr       [NUM_BANK]          registered: 1 = write, 0 = read
//   bank_row      [NUM_BANK*ROW_W]    registered row per bank
//   bank_ocid     [NUM_BANK*OC_W]     registered OC id per bank (0 on writes)
module rf_bank_arbiter #(
  parameter int NUM_OC       = 4,
  parameter int NUM_BANK     = 4,
  parameter int ROW_W        = 3,
  parameter int STARVE_LIMIT = 3,
  localparam int OC_W   = (NUM_OC > 1) ? $clog2(NUM_OC) : 1,
  localparam int BANK_W = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1,
  localparam int CNT_W  = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_OC-1:0]          oc_req_valid,
  input  logic [NUM_OC*BANK_W-1:0]   oc_req_bank,
  input  logic [NUM_OC*ROW_W-1:0]    oc_req_row,
  output logic [NUM_OC-1:0]          oc_req_ready,
  input  logic                       wb_valid,
  input  logic [BANK_W-1:0]          wb_bank,
  input  logic [ROW_W-1:0]           wb_row,
  output logic                       wb_ready,
  output logic [NUM_BANK-1:0]        bank_en,
  output logic [NUM_BANK-1:0]        bank_wr,
  output logic [NUM_BANK*ROW_W-1:0]  bank_row,
  output logic [NUM_BANK*OC_W-1:0]   bank_ocid
);

  logic [NUM_BANK-1:0]      pend;
  logic [NUM_BANK-1:0]      blocked;   // forced cycle with a read waiting: write refused
  logic [NUM_BANK-1:0]      wr_win;
  logic [NUM_BANK-1:0]      rd_grant;
  logic [NUM_BANK*OC_W-1:0] winner_flat;

  genvar gi;

  generate
    for (gi = 0; gi < NUM_BANK; gi++) begin : g_bank
      logic [NUM_OC-1:0] req_vec;
      logic [OC_W-1:0]   winner;
      logic [OC_W-1:0]   rr_ptr_reg;
      logic [CNT_W-1:0]  starve_cnt_reg;
      logic              en_reg;
      logic              wr_reg;
      logic [ROW_W-1:0]  row_reg;
      logic [OC_W-1:0]   ocid_reg;

      always_comb begin
        req_vec = '0;
        for (int i = 0; i < NUM_OC; i++) begin
          req_vec[i] = oc_req_valid[i] &&
                       (oc_req_bank[i*BANK_W +: BANK_W] == BANK_W'(gi));
        end
      end

      assign pend[gi]     = |req_vec;
      assign blocked[gi]  = pend[gi] && (starve_cnt_reg == CNT_W'(STARVE_LIMIT));
      assign wr_win[gi]   = wb_valid && (wb_bank == BANK_W'(gi)) && !blocked[gi];
      assign rd_grant[gi] = pend[gi] && !wr_win[gi];

      // First requester at or after rr_ptr, wrapping.
      always_comb begin : rr_search
        logic found;
        int   idx;
        found  = 1'b0;
        idx    = 0;
        winner = '0;
        for (int k = 0; k < NUM_OC; k++) begin
          idx = (int'(rr_ptr_reg) + k) % NUM_OC;
          if (!found && req_vec[idx]) begin
            winner = OC_W'(idx);
            found  = 1'b1;
          end
        end
      end

      assign winner_flat[gi*OC_W +: OC_W] = winner;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          en_reg         <= 1'b0;
          wr_reg         <= 1'b0;
          row_reg        <= '0;
          ocid_reg       <= '0;
          rr_ptr_reg     <= '0;
          starve_cnt_reg <= '0;
        end else begin
          en_reg <= wr_win[gi] || rd_grant[gi];
          wr_reg <= wr_win[gi];
          if (wr_win[gi]) begin
            row_reg  <= wb_row;
            ocid_reg <= '0;
          end else if (rd_grant[gi]) begin
            row_reg  <= oc_req_row[int'(winner)*ROW_W +: ROW_W];
            ocid_reg <= winner;
          end else begin
            row_reg  <= '0;
            ocid_reg <= '0;
          end

          if (rd_grant[gi]) begin
            rr_ptr_reg <= OC_W'((int'(winner) + 1) % NUM_OC);
          end

          // Count only cycles where a read waited behind a write; anything
          // else (read served, or nobody waiting) restarts the count.
          if (pend[gi] && wr_win[gi]) begin
            if (starve_cnt_reg != CNT_W'(STARVE_LIMIT)) begin
              starve_cnt_reg <= starve_cnt_reg + 1'b1;
            end
          end else begin
            starve_cnt_reg <= '0;
          end
        end
      end

      assign bank_en[gi]                   = en_reg;
      assign bank_wr[gi]                   = wr_reg;
      assign bank_row[gi*ROW_W +: ROW_W]   = row_reg;
      assign bank_ocid[gi*OC_W +: OC_W]    = ocid_reg;
    end
  endgenerate

  // Each OC targets exactly one bank, so it can be granted at most once.
  generate
    for (gi = 0; gi < NUM_OC; gi++) begin : g_oc
      logic [BANK_W-1:0] bank_sel;
      assign bank_sel = oc_req_bank[gi*BANK_W +: BANK_W];
      assign oc_req_ready[gi] = rst && oc_req_valid[gi] && rd_grant[bank_sel] &&
                                (winner_flat[int'(bank_sel)*OC_W +: OC_W] == OC_W'(gi));
    end
  endgenerate

  assign wb_ready = rst && !blocked[wb_bank];

endmodule
